// File: rtl/pmc_dump_ctrl_if.sv
// Stream port of the PMC dump sequencer: one indexed counter word per valid/ready transfer.
interface pmc_dump_ctrl_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned IDX_W = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [CNT_W-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, out_idx, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_idx, out_data, out_last, output out_ready);
endinterface

// File: rtl/pmc_dump_ctrl.sv
// PMC readout sequencer: snapshots the whole counter bank in one edge, streams it
// word by word, then optionally pulses the bank clear.
module pmc_dump_ctrl #(
  parameter int unsigned NUM_CNT = 25,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic                     clear_after_i,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_in_i,
  pmc_dump_ctrl_if.master          dump_if,
  output logic                     busy_o,
  output logic                     pmc_clear_o,
  output logic                     done_o,
  output logic [15:0]              dump_count_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SNAP   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  logic [2:0]       state_q, state_d;
  logic             clr_q, clr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             pmc_clear_q, pmc_clear_d;
  logic             done_q, done_d;
  logic [15:0]      dump_count_q, dump_count_d;
  logic [15:0]      dump_count_inc;
  logic [IDX_W-1:0] idx_nxt;
  logic             snap_load_c;
  logic [CNT_W-1:0] snap_q [NUM_CNT];

  assign idx_nxt        = idx_q + IDX_W'(1);
  assign dump_count_inc = (dump_count_q == 16'hFFFF) ? dump_count_q : dump_count_q + 16'd1;
  assign snap_load_c    = (state_q == S_SNAP);

  // Whole bank captured on the same edge so the dump is a coherent snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_CNT); k++) snap_q[k] <= '0;
    end else if (snap_load_c) begin
      for (int k = 0; k < int'(NUM_CNT); k++) snap_q[k] <= cnt_in_i[k*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_q        <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      pmc_clear_q  <= 1'b0;
      done_q       <= 1'b0;
      dump_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      pmc_clear_q  <= pmc_clear_d;
      done_q       <= done_d;
      dump_count_q <= dump_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    idx_d        = idx_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    pmc_clear_d  = 1'b0;
    done_d       = 1'b0;
    dump_count_d = dump_count_q;

    case (state_q)
      S_IDLE: begin
        clr_d = clear_after_i;
        if (start_i) state_d = S_SNAP;
      end
      // First word comes straight from the bank input, matching what the snapshot takes
      S_SNAP: begin
        state_d = S_STREAM;
        idx_d   = '0;
        data_d  = cnt_in_i[CNT_W-1:0];
        valid_d = 1'b1;
        last_d  = (LAST_IDX == '0);
      end
      S_STREAM: begin
        if (valid_q && dump_if.out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (clr_q) begin
              state_d     = S_CLEAR;
              pmc_clear_d = 1'b1;
            end else begin
              state_d      = S_DONE;
              done_d       = 1'b1;
              dump_count_d = dump_count_inc;
            end
          end else begin
            idx_d  = idx_nxt;
            data_d = snap_q[idx_nxt];
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      S_CLEAR: begin
        state_d      = S_DONE;
        done_d       = 1'b1;
        dump_count_d = dump_count_inc;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign dump_if.out_valid = valid_q;
  assign dump_if.out_idx   = idx_q;
  assign dump_if.out_data  = data_q;
  assign dump_if.out_last  = last_q;
  assign busy_o            = busy_q;
  assign pmc_clear_o       = pmc_clear_q;
  assign done_o            = done_q;
  assign dump_count_o      = dump_count_q;

endmodule

// File: tb/tb_pmc_dump_ctrl.sv
// Scoreboard bench for pmc_dump_ctrl: directed dumps with expected words queued at start.
module tb_pmc_dump_ctrl;
  localparam int unsigned NUM_CNT = 25;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned IDX_W   = 5;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] data;
    logic             last;
  } word_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     clear_after;
  logic [NUM_CNT*CNT_W-1:0] cnt;
  logic                     rdy;
  logic                     busy, pmc_clear, done;
  logic [15:0]              dump_count;

  pmc_dump_ctrl_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dif ();
  assign dif.out_ready = rdy;

  pmc_dump_ctrl #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .clear_after_i(clear_after),
    .cnt_in_i     (cnt),
    .dump_if      (dif),
    .busy_o       (busy),
    .pmc_clear_o  (pmc_clear),
    .done_o       (done),
    .dump_count_o (dump_count)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;
  word_t expq[$];
  int    words, clr_cnt, done_cnt;
  int    last_cyc, clr_cyc, done_cyc;
  logic  bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  logic  stall_q = 1'b0;
  logic [IDX_W-1:0] p_idx;
  logic [CNT_W-1:0] p_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready driver: always ready, or a repeating 1-0-0-1 pattern
  always @(posedge clk) begin
    #1;
    rdy = bp_mode ? bp_pat[cyc[1:0]] : 1'b1;
  end

  // Monitor: pops on every transfer, checks hold-stability during stalls, logs pulses
  always @(negedge clk) begin
    word_t w;
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 64'(dif.out_valid), 64'd1);
        chk("hold_idx", 64'(dif.out_idx), 64'(p_idx));
        chk("hold_data", 64'(dif.out_data), 64'(p_data));
      end
      if (dif.out_valid && dif.out_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got idx %0d data %0h, expected no word", dif.out_idx, dif.out_data);
        end else begin
          w = expq.pop_front();
          chk("word_idx", 64'(dif.out_idx), 64'(w.idx));
          chk("word_data", 64'(dif.out_data), 64'(w.data));
          chk("word_last", 64'(dif.out_last), 64'(w.last));
        end
        words++;
        if (dif.out_last) last_cyc = cyc;
      end
      stall_q = dif.out_valid && !dif.out_ready;
      p_idx   = dif.out_idx;
      p_data  = dif.out_data;
      if (pmc_clear) begin clr_cnt++; clr_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic clear_stats();
    words = 0; clr_cnt = 0; done_cnt = 0;
    last_cyc = -1; clr_cyc = -1; done_cyc = -1;
  endtask

  // Loads the bank with value base + k*step and queues the matching expected stream
  task automatic load_and_expect(input logic [CNT_W-1:0] base, input logic [CNT_W-1:0] step);
    word_t w;
    for (int k = 0; k < int'(NUM_CNT); k++) begin
      cnt[k*CNT_W +: CNT_W] = base + CNT_W'(k) * step;
      w.idx  = IDX_W'(k);
      w.data = base + CNT_W'(k) * step;
      w.last = (k == int'(NUM_CNT) - 1);
      expq.push_back(w);
    end
  endtask

  task automatic start_dump(input logic ca);
    start = 1'b1;
    clear_after = ca;
    @(posedge clk); #1;
    start = 1'b0;
    clear_after = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, expected 0", name, busy, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; clear_after = 1'b0; cnt = '0; rdy = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_idx", 64'(dif.out_idx), 64'd0);
    chk("rst_data", 64'(dif.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(dump_count), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic dump: counter k = 100+k, no clear
    clear_stats();
    load_and_expect(32'd100, 32'd1);
    s = cyc;
    start_dump(1'b0);
    chk("t1_busy_rise", 64'(busy), 64'd1);
    wait_idle("t1");
    chk("t1_words", 64'(words), 64'(NUM_CNT));
    chk("t1_q_empty", 64'(expq.size()), 64'd0);
    chk("t1_clear_pulses", 64'(clr_cnt), 64'd0);
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);
    chk("t1_done_after_last", 64'(done_cyc - last_cyc), 64'd1);
    chk("t1_total_cycles", 64'(done_cyc - s), 64'(NUM_CNT + 2));
    chk("t1_count", 64'(dump_count), 64'd1);

    // Backpressure plus bank change mid-stream
    clear_stats();
    bp_mode = 1'b1;
    load_and_expect(32'h1000_0000, 32'd3);
    start_dump(1'b0);
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < int'(NUM_CNT); k++) cnt[k*CNT_W +: CNT_W] = 32'hDEADBEEF;
    wait_idle("t2");
    bp_mode = 1'b0;
    chk("t2_words", 64'(words), 64'(NUM_CNT));
    chk("t2_q_empty", 64'(expq.size()), 64'd0);
    chk("t2_done_pulses", 64'(done_cnt), 64'd1);
    chk("t2_count", 64'(dump_count), 64'd2);

    // Clear after dump
    clear_stats();
    load_and_expect(32'hA5A5_0000, 32'h0001_0001);
    s = cyc;
    start_dump(1'b1);
    wait_idle("t3");
    chk("t3_words", 64'(words), 64'(NUM_CNT));
    chk("t3_clear_pulses", 64'(clr_cnt), 64'd1);
    chk("t3_clear_after_last", 64'(clr_cyc - last_cyc), 64'd1);
    chk("t3_done_after_clear", 64'(done_cyc - clr_cyc), 64'd1);
    chk("t3_total_cycles", 64'(done_cyc - s), 64'(NUM_CNT + 3));
    chk("t3_count", 64'(dump_count), 64'd3);

    // Start pulsed during STREAM is ignored
    clear_stats();
    load_and_expect(32'd7, 32'd11);
    start_dump(1'b0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t4");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_restart", 64'(busy), 64'd0);
    chk("t4_words", 64'(words), 64'(NUM_CNT));
    chk("t4_done_pulses", 64'(done_cnt), 64'd1);
    chk("t4_count", 64'(dump_count), 64'd4);

    // Reset at idx 10
    clear_stats();
    load_and_expect(32'd500, 32'd2);
    start_dump(1'b1);
    s = 0;
    while (!(dif.out_valid && dif.out_idx == IDX_W'(10)) && s < 100) begin
      @(posedge clk); #1;
      s++;
    end
    chk("t5_reached_idx10", 64'(dif.out_idx), 64'd10);
    reset = 1'b1;
    #1;
    expq.delete();
    chk("t5_valid", 64'(dif.out_valid), 64'd0);
    chk("t5_idx", 64'(dif.out_idx), 64'd0);
    chk("t5_data", 64'(dif.out_data), 64'd0);
    chk("t5_last", 64'(dif.out_last), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_count", 64'(dump_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_no_clear", 64'(clr_cnt), 64'd0);

    clear_stats();
    load_and_expect(32'h0000_0007, 32'd13);
    start_dump(1'b0);
    wait_idle("t6");
    chk("t6_words", 64'(words), 64'(NUM_CNT));
    chk("t6_q_empty", 64'(expq.size()), 64'd0);
    chk("t6_count", 64'(dump_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pmc_dump_ctrl.md
# pmc_dump_ctrl

Readout sequencer for the performance-monitoring counter bank (`PMC_unit`). On a dump request it atomically snapshots all counters in one cycle, then streams them one per transfer over a valid/ready port, indexed, to the debug/host interface. It can optionally issue a one-cycle clear pulse to the counter bank after the last word. The block sits beside `PMC_unit` and owns its clear path; its `pmc_clear` output is ORed into the counter bank's reset.

## Interface
Parameters:
- `NUM_CNT`, 25 — counters in the bank: stall, CPI numerator/denominator, arith, mem access/read/write, 18 per-instruction.
- `CNT_W`, 32 — counter width.
- `IDX_W`, 5 — index width; `2**IDX_W >= NUM_CNT` required.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `start`  in  1  — dump request; sampled only in IDLE.
- `clear_after`  in  1  — sampled with `start`; 1 = clear the bank after the dump.
- `cnt_in`  in  NUM_CNT*CNT_W  — counter k occupies bits `[k*CNT_W +: CNT_W]`.
- `out_valid`  out  1  — stream word valid.
- `out_ready`  in  1  — consumer accepts the word.
- `out_idx`  out  IDX_W  — counter index of the current word.
- `out_data`  out  CNT_W  — snapshot value of counter `out_idx`.
- `out_last`  out  1  — current word is index NUM_CNT-1.
- `busy`  out  1  — high in any state other than IDLE.
- `pmc_clear`  out  1  — one-cycle clear pulse to the counter bank.
- `done`  out  1  — one-cycle pulse when the dump completes.
- `dump_count`  out  16  — completed dumps, saturating at 16'hFFFF.

## Operation
- States: IDLE, SNAP, STREAM, CLEAR, DONE.
- IDLE:
  - `start`=1 → SNAP.
  - Latch `clear_after` into `clr_q`.
- SNAP (1 cycle):
  - Every snapshot register gets `cnt_in` in the same edge.
  - `idx` ← 0.
  - → STREAM.
- STREAM:
  - `out_valid`=1, `out_data`=snap[idx], `out_idx`=idx, `out_last`=(idx==NUM_CNT-1).
  - Transfer happens on `out_valid & out_ready`.
  - Transfer with not-last → `idx`+1.
  - Transfer with last → CLEAR if `clr_q`, else DONE.
- CLEAR (1 cycle): `pmc_clear`=1 → DONE.
- DONE (1 cycle):
  - `done`=1.
  - `dump_count` increments unless it is already 16'hFFFF.
  - → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `cnt_in` changes after SNAP do not affect streamed data.
- Outputs `out_idx`, `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- `out_valid` never drops before its transfer.
- `idx` never exceeds NUM_CNT-1; there is no wrap.

## Timing
- Reset values:
  - State = IDLE.
  - `out_valid`, `out_last`, `busy`, `pmc_clear`, `done` = 0.
  - `out_idx`, `out_data`, `dump_count`, all snapshot registers = 0.
- All outputs are registered or decoded from registered state; there is no combinational path from `out_ready` to `out_data` or `out_idx`.
- Dump cycle count:
  - `start` seen at edge E0 → SNAP during E0..E1; snapshot taken at E1.
  - `out_valid` rises after E1.
  - With `out_ready` held at 1: NUM_CNT STREAM cycles, +1 CLEAR cycle if `clr_q`, then 1 DONE cycle.
  - Total = NUM_CNT+2 cycles (no clear) or NUM_CNT+3 cycles (with clear).
- `busy` rises the cycle after `start` is accepted and falls after the DONE cycle.
- `start` held high continuously → a new dump starts on the first IDLE cycle after DONE (back-to-back dumps).
- Reset asserted mid-dump:
  - Immediate return to IDLE with all outputs at their reset values.
  - No `pmc_clear` or `done` pulse is emitted.
  - `dump_count` is cleared.

## Test plan
- Reset, then set `cnt_in` counter k = 100+k, pulse `start` with `clear_after`=0, hold `out_ready`=1 → exactly 25 words:
  - idx 0..24, data 100..124, `out_last` only at idx 24.
  - `done` one cycle later; `pmc_clear` never high; `dump_count`=1.
- Backpressure: toggle `out_ready` 1-0-0-1 → every word is held stable while stalled, there are no duplicates or skips, and total transfers = 25.
- Change every `cnt_in` to 32'hDEADBEEF during STREAM → streamed data still equals the values captured at SNAP.
- `clear_after`=1 → `pmc_clear` high for exactly 1 cycle, the cycle after the idx-24 transfer; `done` follows 1 cycle later.
- Pulse `start` during STREAM → ignored: no restart, still 25 words, `dump_count` increments by 1.
- Assert `reset` at idx 10 → outputs immediately at reset values, no `done`, `dump_count`=0; a subsequent `start` runs a full 25-word dump.
